// File: rtl/control_fsm.sv
// Multi-cycle MIPS-subset control unit: a state register plus combinational
// datapath controls decoded from the current state, opcode, funct and zero.
module control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               ir_we,
    output logic               mem_addr_sel,
    output logic               mem_we,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wb_sel,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    state_e state_q;
    state_e state_d;
    logic   pc_we_s;
    logic   ir_we_s;
    logic   mem_we_s;
    logic   reg_we_s;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; illegal encodings fall back to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (opcode)
                    6'h00: begin
                        if (funct == 6'h08) begin
                            state_d = JUMP;
                        end else begin
                            state_d = EXEC_R;
                        end
                    end
                    6'h08, 6'h0E: state_d = EXEC_I;
                    6'h23, 6'h2B: state_d = MEM_ADDR;
                    6'h05:        state_d = BRANCH;
                    6'h02, 6'h03: state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            EXEC_R, EXEC_I: state_d = WB_ALU;
            MEM_ADDR: begin
                if (opcode == 6'h2B) begin
                    state_d = MEM_WR;
                end else if (opcode == 6'h23) begin
                    state_d = MEM_RD;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM_RD:  state_d = WB_MEM;
            default: state_d = FETCH;
        endcase
    end

    // Datapath controls per state; write enables are gated by reset below.
    always_comb begin
        pc_we_s      = 1'b0;
        pc_src       = 2'd0;
        ir_we_s      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_we_s     = 1'b0;
        reg_we_s     = 1'b0;
        reg_dst      = 2'd0;
        wb_sel       = 2'd0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        alu_op       = ALU_ADD;
        case (state_q)
            FETCH: begin
                ir_we_s   = 1'b1;
                pc_we_s   = 1'b1;
                alu_src_b = 2'd1;
            end
            DECODE: alu_src_b = 2'd3;
            EXEC_R: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'h22:   alu_op = ALU_SUB;
                    6'h2A:   alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                if (opcode == 6'h0E) begin
                    alu_op = ALU_XOR;
                end else begin
                    alu_op = ALU_ADD;
                end
            end
            WB_ALU: begin
                reg_we_s = 1'b1;
                if (opcode == 6'h00) begin
                    reg_dst = 2'd1;
                end else begin
                    reg_dst = 2'd0;
                end
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            MEM_RD: mem_addr_sel = 1'b1;
            MEM_WR: begin
                mem_addr_sel = 1'b1;
                mem_we_s     = 1'b1;
            end
            WB_MEM: begin
                reg_we_s = 1'b1;
                wb_sel   = 2'd1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'd1;
                pc_we_s   = ~zero;
            end
            JUMP: begin
                pc_we_s = 1'b1;
                if ((opcode == 6'h00) && (funct == 6'h08)) begin
                    pc_src = 2'd3;
                end else begin
                    pc_src = 2'd2;
                end
                if (opcode == 6'h03) begin
                    reg_we_s = 1'b1;
                    reg_dst  = 2'd2;
                    wb_sel   = 2'd2;
                end else begin
                    reg_we_s = 1'b0;
                end
            end
            default: begin
                pc_we_s = 1'b0;
            end
        endcase
    end

    // Reset suppresses every architectural write in the same cycle.
    always_comb begin
        if (reset) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            mem_we = 1'b0;
            reg_we = 1'b0;
        end else begin
            pc_we  = pc_we_s;
            ir_we  = ir_we_s;
            mem_we = mem_we_s;
            reg_we = reg_we_s;
        end
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed and random instructions checked
// cycle by cycle against a per-instruction micro-operation model.
module tb_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       mem_addr_sel;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } obs_t;

    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BNE = 4;
    localparam int C_J = 5, C_JAL = 6, C_JR = 7, C_NOP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       pc_we, ir_we, mem_addr_sel, mem_we, reg_we, alu_src_a;
    logic [1:0] pc_src, reg_dst, wb_sel, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;

    int   n_checks = 0;
    int   n_fail = 0;
    obs_t tr [0:9];
    int   n_cyc;

    control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_addr_sel(mem_addr_sel),
        .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        return {state, pc_we, pc_src, ir_we, mem_addr_sel, mem_we, reg_we,
                reg_dst, wb_sel, alu_src_a, alu_src_b, alu_op};
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00 && fn == 6'h08) return C_JR;
        case (op)
            6'h00:        return C_R;
            6'h08, 6'h0E: return C_I;
            6'h23:        return C_LW;
            6'h2B:        return C_SW;
            6'h05:        return C_BNE;
            6'h02:        return C_J;
            6'h03:        return C_JAL;
            default:      return C_NOP;
        endcase
    endfunction

    function automatic int model_len(input logic [5:0] op, input logic [5:0] fn);
        case (classify(op, fn))
            C_R, C_I, C_SW: return 4;
            C_LW:           return 5;
            C_NOP:          return 2;
            default:        return 3;
        endcase
    endfunction

    // Expected controls for micro-step k of an instruction (step len = next fetch).
    function automatic obs_t model_step(input logic [5:0] op, input logic [5:0] fn,
                                        input logic z, input int k);
        obs_t e = '0;
        int   c = classify(op, fn);
        if (k == 0 || k == model_len(op, fn)) begin
            e.st = 4'd0; e.ir_we = 1'b1; e.pc_we = 1'b1; e.alu_src_b = 2'd1;
        end else if (k == 1) begin
            e.st = 4'd1; e.alu_src_b = 2'd3;
        end else if (c == C_R) begin
            if (k == 2) begin
                e.st = 4'd2; e.alu_src_a = 1'b1;
                e.alu_op = (fn == 6'h22) ? 3'b001 : (fn == 6'h2A) ? 3'b011 : 3'b000;
            end else begin
                e.st = 4'd7; e.reg_we = 1'b1; e.reg_dst = 2'd1;
            end
        end else if (c == C_I) begin
            if (k == 2) begin
                e.st = 4'd3; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                e.alu_op = (op == 6'h0E) ? 3'b010 : 3'b000;
            end else begin
                e.st = 4'd7; e.reg_we = 1'b1;
            end
        end else if (c == C_LW || c == C_SW) begin
            if (k == 2) begin
                e.st = 4'd4; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
            end else if (k == 3) begin
                e.st = (c == C_LW) ? 4'd5 : 4'd6; e.mem_addr_sel = 1'b1;
                e.mem_we = (c == C_SW);
            end else begin
                e.st = 4'd8; e.reg_we = 1'b1; e.wb_sel = 2'd1;
            end
        end else if (c == C_BNE) begin
            e.st = 4'd9; e.alu_src_a = 1'b1; e.alu_op = 3'b001;
            e.pc_src = 2'd1; e.pc_we = ~z;
        end else begin
            e.st = 4'd10; e.pc_we = 1'b1;
            e.pc_src = (c == C_JR) ? 2'd3 : 2'd2;
            if (c == C_JAL) begin
                e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wb_sel = 2'd2;
            end
        end
        return e;
    endfunction

    // Drives one instruction from FETCH, sampling mid-cycle until FETCH returns.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        n_cyc = -1;
        for (int k = 0; k < 10; k++) begin
            opcode = op; funct = fn; zero = z;
            #1;
            tr[k] = sample();
            if (k > 0 && tr[k].st == 4'd0) begin
                n_cyc = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({pc_we, ir_we, mem_we, reg_we} !== 4'b0000 || state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hold: we=%b state=%0d required we=0000 state=0",
                     {pc_we, ir_we, mem_we, reg_we}, state);
        end
        reset = 1'b0; #1;
        n_checks++;
        if (sample() !== model_step(6'h00, 6'h00, 1'b0, 0)) begin
            n_fail++;
            $display("FAIL reset_release: got %h required %h", sample(),
                     model_step(6'h00, 6'h00, 1'b0, 0));
        end
    endtask

    task automatic test_directed();
        logic [5:0] ops [0:12];
        logic [5:0] fns [0:12];
        ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0E, 6'h23, 6'h2B,
                6'h02, 6'h03, 6'h00, 6'h3F, 6'h04};
        fns = '{6'h20, 6'h22, 6'h2A, 6'h25, 6'h11, 6'h00, 6'h00, 6'h00,
                6'h00, 6'h00, 6'h08, 6'h00, 6'h00};
        for (int i = 0; i < 13; i++) begin
            run_instr(ops[i], fns[i], 1'b0);
            n_checks++;
            if (n_cyc !== model_len(ops[i], fns[i])) begin
                n_fail++;
                $display("FAIL directed_len op=%h fn=%h: cycles %0d required %0d",
                         ops[i], fns[i], n_cyc, model_len(ops[i], fns[i]));
            end
            for (int k = 0; k <= n_cyc; k++) begin
                n_checks++;
                if (tr[k] !== model_step(ops[i], fns[i], 1'b0, k)) begin
                    n_fail++;
                    $display("FAIL directed op=%h fn=%h step %0d: got %h required %h",
                             ops[i], fns[i], k, tr[k], model_step(ops[i], fns[i], 1'b0, k));
                end
            end
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 2; i++) begin
            logic z = (i == 0);
            run_instr(6'h05, 6'h00, z);
            n_checks++;
            if (n_cyc !== 3) begin
                n_fail++;
                $display("FAIL branch_len zero=%b: cycles %0d required 3", z, n_cyc);
            end
            for (int k = 0; k <= n_cyc; k++) begin
                n_checks++;
                if (tr[k] !== model_step(6'h05, 6'h00, z, k)) begin
                    n_fail++;
                    $display("FAIL branch zero=%b step %0d: got %h required %h",
                             z, k, tr[k], model_step(6'h05, 6'h00, z, k));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (state !== 4'd6 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_memwr: state=%0d mem_we=%b required 6/1", state, mem_we);
        end
        reset = 1'b1; #1;
        n_checks++;
        if ({pc_we, ir_we, mem_we, reg_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_we: we=%b required 0000", {pc_we, ir_we, mem_we, reg_we});
        end
        @(negedge clk); #1;
        n_checks++;
        if (state !== 4'd0 || {pc_we, ir_we, mem_we, reg_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_state: state=%0d we=%b required 0/0000",
                     state, {pc_we, ir_we, mem_we, reg_we});
        end
        reset = 1'b0; #1;
        n_checks++;
        if (sample() !== model_step(6'h2B, 6'h00, 1'b0, 0)) begin
            n_fail++;
            $display("FAIL mid_refetch: got %h required %h", sample(),
                     model_step(6'h2B, 6'h00, 1'b0, 0));
        end
    endtask

    task automatic test_random();
        logic [5:0] op_pool [0:7];
        logic [5:0] fn_pool [0:3];
        logic [5:0] op, fn;
        logic       z;
        op_pool = '{6'h00, 6'h08, 6'h0E, 6'h23, 6'h2B, 6'h05, 6'h02, 6'h03};
        fn_pool = '{6'h20, 6'h22, 6'h2A, 6'h08};
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 3)];
            z  = 1'($urandom);
            run_instr(op, fn, z);
            n_checks++;
            if (n_cyc !== model_len(op, fn)) begin
                n_fail++;
                $display("FAIL random_len op=%h fn=%h: cycles %0d required %0d",
                         op, fn, n_cyc, model_len(op, fn));
            end
            for (int k = 0; k <= n_cyc; k++) begin
                n_checks++;
                if (tr[k] !== model_step(op, fn, z, k)) begin
                    n_fail++;
                    $display("FAIL random op=%h fn=%h z=%b step %0d: got %h required %h",
                             op, fn, z, k, tr[k], model_step(op, fn, z, k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_branch();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter: STATE_W, 4, width of the state debug output.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag for the current cycle.
REQ-007 pc_we  output  1  PC register load enable.
REQ-008 pc_src  output  2  PC next-value select: 0 ALU result, 1 ALUOut (branch target), 2 jump target, 3 register rs.
REQ-009 ir_we  output  1  instruction register load enable.
REQ-010 mem_addr_sel  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-011 mem_we  output  1  data memory write enable.
REQ-012 reg_we  output  1  register file write enable.
REQ-013 reg_dst  output  2  write-register select: 0 rt, 1 rd, 2 r31.
REQ-014 wb_sel  output  2  write-data select: 0 ALUOut, 1 memory data register, 2 PC.
REQ-015 alu_src_a  output  1  ALU A select: 0 PC, 1 register A.
REQ-016 alu_src_b  output  2  ALU B select: 0 register B, 1 constant 4, 2 sign-extended imm, 3 sign-extended imm<<2.
REQ-017 alu_op  output  3  000 ADD, 001 SUB, 010 XOR, 011 SLT.
REQ-018 state  output  STATE_W  current state encoding (debug).

Function
REQ-019 States and encodings SHALL be: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JUMP 10; encodings 11-15 are illegal.
REQ-020 State register SHALL update only on rising clk; all outputs SHALL be combinational functions of state, opcode, funct and zero (Moore, except pc_we in BRANCH).
REQ-021 Any output not listed for a state SHALL be 0.
REQ-022 FETCH: ir_we=1, pc_we=1, pc_src=0, mem_addr_sel=0, alu_src_a=0, alu_src_b=1, alu_op=ADD; next DECODE.
REQ-023 DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut); next by opcode: 0x00 with funct 0x08 -> JUMP; 0x00 otherwise -> EXEC_R; 0x08/0x0E -> EXEC_I; 0x23/0x2B -> MEM_ADDR; 0x05 -> BRANCH; 0x02/0x03 -> JUMP; any other opcode -> FETCH (treated as NOP).
REQ-024 EXEC_R: alu_src_a=1, alu_src_b=0, alu_op from funct (0x20 ADD, 0x22 SUB, 0x2A SLT, other ADD); next WB_ALU.
REQ-025 EXEC_I: alu_src_a=1, alu_src_b=2, alu_op ADD for 0x08, XOR for 0x0E; next WB_ALU.
REQ-026 WB_ALU: reg_we=1, wb_sel=0, reg_dst=1 if opcode=0x00 else 0; next FETCH.
REQ-027 MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD; next MEM_RD for 0x23, MEM_WR for 0x2B.
REQ-028 MEM_RD: mem_addr_sel=1; next WB_MEM. WB_MEM: reg_we=1, wb_sel=1, reg_dst=0; next FETCH.
REQ-029 MEM_WR: mem_addr_sel=1, mem_we=1; next FETCH.
REQ-030 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1, pc_we=~zero; next FETCH.
REQ-031 JUMP: pc_we=1; pc_src=3 for JR else 2; for 0x03 also reg_we=1, reg_dst=2, wb_sel=2 (writes incremented PC); next FETCH.
REQ-032 Cycle counts per instruction SHALL be: R-type/ADDI/XORI 4, LW 5, SW 4, BNE 3, J/JAL/JR 3, unknown opcode 2.
REQ-033 Illegal state encodings SHALL transition to FETCH on the next edge with all write enables 0.

Reset
REQ-034 With reset high at a rising edge, state SHALL become FETCH regardless of current state.
REQ-035 While reset is high, pc_we, ir_we, mem_we and reg_we SHALL be forced 0; other outputs may take FETCH values.
REQ-036 First FETCH actions SHALL occur on the first rising edge after reset deasserts; reset mid-instruction SHALL abandon it with no further writes.

Verification
REQ-037 Reset, then opcode=0x00 funct=0x20 -> states 0,1,2,7,0; reg_we=1 and reg_dst=1 only in state 7.
REQ-038 opcode=0x23 -> states 0,1,4,5,8,0; mem_addr_sel=1 in 5; reg_we=1, wb_sel=1 in 8; mem_we never 1.
REQ-039 opcode=0x05 with zero=1 in BRANCH -> pc_we=0; repeat with zero=0 -> pc_we=1, pc_src=1; both return to FETCH.
REQ-040 opcode=0x03 -> state 10 with pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_sel=2; opcode=0x00 funct=0x08 -> pc_src=3, reg_we=0.
REQ-041 opcode=0x3F -> states 0,1,0 with no write enables in DECODE; reset asserted in MEM_WR -> mem_we=0 that cycle, state=0 next edge.
